// File: rtl/pipe3_fwd_core.sv
`default_nettype none
// ============================================================================
// Module   : pipe3_fwd_core
// Brief    : Three-stage ALU pipeline with a register file and EX/WB forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module pipe3_fwd_core #(
    parameter int DW      = 32,
    parameter int NREG    = 32,
    parameter bit FWD_EN  = 1'b1,
    parameter bit ZERO_R0 = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   InstrIn,
    input  logic          in_valid,
    input  logic          stall,
    output logic          in_ready,
    output logic [DW-1:0] Out,
    output logic          out_valid,
    output logic [15:0]   retire_cnt
);
    localparam int c_AW  = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int c_SHW = $clog2(DW);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_AND = 3'b010;
    localparam logic [2:0] c_OP_OR  = 3'b011;
    localparam logic [2:0] c_OP_XOR = 3'b100;
    localparam logic [2:0] c_OP_SHL = 3'b101;
    localparam logic [2:0] c_OP_SHR = 3'b110;
    localparam logic [2:0] c_OP_MOV = 3'b111;

    // S1: decoded fields
    logic            r_s1Valid;
    logic [2:0]      r_s1Op;
    logic            r_s1DataSrc;
    logic            r_s1We;
    logic [c_AW-1:0] r_s1Wsel;
    logic [c_AW-1:0] r_s1Rs1;
    logic [c_AW-1:0] r_s1Rs2;
    logic [15:0]     r_s1Imm;

    // S2: resolved operands
    logic            r_s2Valid;
    logic [2:0]      r_s2Op;
    logic            r_s2We;
    logic [c_AW-1:0] r_s2Wsel;
    logic [DW-1:0]   r_s2A;
    logic [DW-1:0]   r_s2B;

    // S3: result
    logic            r_s3Valid;
    logic            r_s3We;
    logic [c_AW-1:0] r_s3Wsel;
    logic [DW-1:0]   r_out;

    logic [15:0]     r_retireCnt;
    logic [DW-1:0]   r_regs [NREG];

    logic [DW-1:0]   w_aluRes;
    logic [DW-1:0]   w_immExt;
    logic [DW-1:0]   w_rdA;
    logic [DW-1:0]   w_rdB;
    logic [DW-1:0]   w_opA;
    logic [DW-1:0]   w_opB;
    logic            w_zeroA;
    logic            w_zeroB;
    logic            w_s3Write;
    logic            w_unusedIgnored;

    assign w_unusedIgnored = InstrIn[26];
    assign w_immExt  = DW'($signed(r_s1Imm));
    assign w_zeroA   = ZERO_R0 && (r_s1Rs1 == '0);
    assign w_zeroB   = ZERO_R0 && (r_s1Rs2 == '0);
    assign w_rdA     = w_zeroA ? '0 : r_regs[r_s1Rs1];
    assign w_rdB     = w_zeroB ? '0 : r_regs[r_s1Rs2];
    assign w_s3Write = r_s3Valid && r_s3We && !stall;

    always_comb begin
        w_aluRes = r_s2B;
        case (r_s2Op)
            c_OP_ADD: w_aluRes = r_s2A + r_s2B;
            c_OP_SUB: w_aluRes = r_s2A - r_s2B;
            c_OP_AND: w_aluRes = r_s2A & r_s2B;
            c_OP_OR:  w_aluRes = r_s2A | r_s2B;
            c_OP_XOR: w_aluRes = r_s2A ^ r_s2B;
            c_OP_SHL: w_aluRes = r_s2A << r_s2B[c_SHW-1:0];
            c_OP_SHR: w_aluRes = r_s2A >> r_s2B[c_SHW-1:0];
            c_OP_MOV: w_aluRes = r_s2B;
            default:  w_aluRes = r_s2B;
        endcase
    end

    // The younger producer (S2) wins over the older one (S3).
    always_comb begin
        w_opA = w_rdA;
        if (FWD_EN && !w_zeroA && r_s2Valid && r_s2We && (r_s2Wsel == r_s1Rs1))
            w_opA = w_aluRes;
        else if (FWD_EN && !w_zeroA && r_s3Valid && r_s3We && (r_s3Wsel == r_s1Rs1))
            w_opA = r_out;
    end

    always_comb begin
        w_opB = w_rdB;
        if (r_s1DataSrc)
            w_opB = w_immExt;
        else if (FWD_EN && !w_zeroB && r_s2Valid && r_s2We && (r_s2Wsel == r_s1Rs2))
            w_opB = w_aluRes;
        else if (FWD_EN && !w_zeroB && r_s3Valid && r_s3We && (r_s3Wsel == r_s1Rs2))
            w_opB = r_out;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1Valid   <= 1'b0;
            r_s1Op      <= '0;
            r_s1DataSrc <= 1'b0;
            r_s1We      <= 1'b0;
            r_s1Wsel    <= '0;
            r_s1Rs1     <= '0;
            r_s1Rs2     <= '0;
            r_s1Imm     <= '0;
            r_s2Valid   <= 1'b0;
            r_s2Op      <= '0;
            r_s2We      <= 1'b0;
            r_s2Wsel    <= '0;
            r_s2A       <= '0;
            r_s2B       <= '0;
            r_s3Valid   <= 1'b0;
            r_s3We      <= 1'b0;
            r_s3Wsel    <= '0;
            r_out       <= '0;
            r_retireCnt <= '0;
        end else if (!stall) begin
            r_s1Valid   <= in_valid;
            r_s1Op      <= InstrIn[31:29];
            r_s1DataSrc <= InstrIn[28];
            r_s1We      <= InstrIn[27];
            r_s1Wsel    <= InstrIn[21 +: c_AW];
            r_s1Rs1     <= InstrIn[16 +: c_AW];
            r_s1Rs2     <= InstrIn[11 +: c_AW];
            r_s1Imm     <= InstrIn[15:0];

            r_s2Valid   <= r_s1Valid;
            r_s2Op      <= r_s1Op;
            r_s2We      <= r_s1We;
            r_s2Wsel    <= r_s1Wsel;
            r_s2A       <= w_opA;
            r_s2B       <= w_opB;

            r_s3Valid   <= r_s2Valid;
            r_s3We      <= r_s2We;
            r_s3Wsel    <= r_s2Wsel;
            if (r_s2Valid)
                r_out   <= w_aluRes;

            if (w_s3Write)
                r_retireCnt <= r_retireCnt + 16'd1;
        end
    end

    // Writes to R0 still retire; only the storage update is dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (w_s3Write && !(ZERO_R0 && (r_s3Wsel == '0))) begin
            r_regs[r_s3Wsel] <= r_out;
        end
    end

    assign in_ready   = ~stall;
    assign Out        = r_out;
    assign out_valid  = r_s3Valid;
    assign retire_cnt = r_retireCnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe3_fwd_core.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe3_fwd_core
// Brief    : Scoreboard bench driving a forwarding and a non-forwarding core.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe3_fwd_core;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] InstrIn = '0;
    logic        in_valid = 1'b0;
    logic        stall = 1'b0;

    logic        irdyF, ovF, irdyN, ovN;
    logic [31:0] outF, outN;
    logic [15:0] rcF, rcN;

    int unsigned total = 0;
    int unsigned bad = 0;
    logic [15:0] expRc = '0;
    logic [31:0] qF[$];
    logic [31:0] qN[$];
    logic [31:0] eF, eN;
    logic [31:0] snapOut;
    logic        snapOv;
    logic [15:0] snapRc;

    always #5 clk = ~clk;

    pipe3_fwd_core #(.DW(32), .NREG(32), .FWD_EN(1'b1), .ZERO_R0(1'b1)) dutF (
        .clk(clk), .rst(rst), .InstrIn(InstrIn), .in_valid(in_valid), .stall(stall),
        .in_ready(irdyF), .Out(outF), .out_valid(ovF), .retire_cnt(rcF)
    );

    pipe3_fwd_core #(.DW(32), .NREG(32), .FWD_EN(1'b0), .ZERO_R0(1'b1)) dutN (
        .clk(clk), .rst(rst), .InstrIn(InstrIn), .in_valid(in_valid), .stall(stall),
        .in_ready(irdyN), .Out(outN), .out_valid(ovN), .retire_cnt(rcN)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [2:0] op, input logic ds, input logic we,
                                        input logic [4:0] wd, input logic [4:0] rs1,
                                        input logic [15:0] low);
        return {op, ds, we, 1'b0, wd, rs1, low};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] wd, input logic [4:0] rs1,
                                         input logic [15:0] imm);
        return enc(3'b000, 1'b1, 1'b1, wd, rs1, imm);
    endfunction

    function automatic logic [31:0] rr(input logic [2:0] op, input logic [4:0] wd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return enc(op, 1'b0, 1'b1, wd, rs1, {rs2, 11'b0});
    endfunction

    // Non-writing read-back: Out = R[rs2]
    function automatic logic [31:0] mov(input logic [4:0] rs2);
        return enc(3'b111, 1'b0, 1'b0, 5'd0, 5'd0, {rs2, 11'b0});
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] expF, input logic [31:0] expN);
        InstrIn  = ins;
        in_valid = 1'b1;
        qF.push_back(expF);
        qN.push_back(expN);
        if (ins[27]) expRc++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: one result per cycle in which S3 is valid and the pipe advances.
    always @(negedge clk) begin
        if (rst && ovF && !stall) begin
            if (qF.size() == 0) begin
                total++; bad++;
                $display("FAIL sbF_unexpected actual=%0h required=none", outF);
            end else begin
                eF = qF.pop_front();
                chk("sbF_out", {32'd0, outF}, {32'd0, eF});
            end
        end
        if (rst && ovN && !stall) begin
            if (qN.size() == 0) begin
                total++; bad++;
                $display("FAIL sbN_unexpected actual=%0h required=none", outN);
            end else begin
                eN = qN.pop_front();
                chk("sbN_out", {32'd0, outN}, {32'd0, eN});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", outF, 0);
        chk("rst_vld", ovF, 0);
        chk("rst_rc", rcF, 0);
        chk("rst_rdy", irdyF, 1);
        stall = 1'b1;
        #1;
        chk("rst_rdy_stall", irdyF, 0);
        stall = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(1);

        // ADDI chain with latency check
        issue(addi(5'd1, 5'd0, 16'd5), 32'd5, 32'd5);
        issue(addi(5'd2, 5'd0, 16'd7), 32'd7, 32'd7);
        idle(1);
        chk("lat_k2_out", outF, 5);
        chk("lat_k2_vld", ovF, 1);
        idle(1);
        chk("lat_k3_out", outF, 7);
        idle(2);
        chk("rc_two", rcF, 2);

        // Back-to-back dependences
        issue(rr(3'b000, 5'd3, 5'd1, 5'd2), 32'd12, 32'd12);
        issue(rr(3'b001, 5'd4, 5'd3, 5'd1), 32'd7, 32'hFFFF_FFFB);
        issue(rr(3'b011, 5'd5, 5'd3, 5'd4), 32'd15, 32'd0);
        idle(4);

        // Stall mid-stream
        issue(addi(5'd7, 5'd0, 16'd3), 32'd3, 32'd3);
        issue(rr(3'b000, 5'd8, 5'd7, 5'd7), 32'd6, 32'd0);
        issue(rr(3'b001, 5'd9, 5'd8, 5'd7), 32'd3, 32'd0);
        snapOut = outF;
        snapOv  = ovF;
        snapRc  = rcF;
        chk("stall_pre_out", outF, 3);
        InstrIn  = rr(3'b100, 5'd10, 5'd9, 5'd8);
        in_valid = 1'b1;
        stall    = 1'b1;
        qF.push_back(32'd5);
        qN.push_back(32'd0);
        expRc++;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("stall_out", outF, snapOut);
            chk("stall_vld", ovF, snapOv);
            chk("stall_rc", rcF, snapRc);
            chk("stall_rdy", irdyF, 0);
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        idle(4);
        chk("rc_after_stall", rcF, expRc);
        issue(mov(5'd7), 32'd3, 32'd3);
        issue(mov(5'd8), 32'd6, 32'd0);
        issue(mov(5'd9), 32'd3, 32'd0);
        issue(mov(5'd10), 32'd5, 32'd0);
        idle(4);

        // R0 stays zero
        issue(addi(5'd0, 5'd0, 16'd9), 32'd9, 32'd9);
        issue(rr(3'b000, 5'd6, 5'd0, 5'd0), 32'd0, 32'd0);
        issue(mov(5'd0), 32'd0, 32'd0);
        idle(4);
        chk("rc_r0F", rcF, expRc);
        chk("rc_r0N", rcN, expRc);

        // Drive retire_cnt to 0xFFFF, then wrap
        begin
            int n;
            n = 32'hFFFF - int'(expRc);
            for (int i = 0; i < n; i++)
                issue(addi(5'd11, 5'd0, 16'd1), 32'd1, 32'd1);
        end
        idle(3);
        chk("rc_ffffF", rcF, 16'hFFFF);
        chk("rc_ffffN", rcN, 16'hFFFF);
        issue(addi(5'd11, 5'd0, 16'd2), 32'd2, 32'd2);
        idle(3);
        chk("rc_wrap", rcF, 16'h0000);

        // Reset while instructions are in flight
        issue(addi(5'd12, 5'd0, 16'd44), 32'd44, 32'd44);
        issue(addi(5'd13, 5'd0, 16'd55), 32'd55, 32'd55);
        issue(addi(5'd14, 5'd0, 16'd66), 32'd66, 32'd66);
        chk("pre_rst_vld", ovF, 1);
        rst = 1'b0;
        #1;
        chk("midrst_vld", ovF, 0);
        chk("midrst_out", outF, 0);
        chk("midrst_rc", rcF, 0);
        chk("midrst_rdy", irdyF, 1);
        qF.delete();
        qN.delete();
        expRc = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle(4);
        chk("postrst_rcF", rcF, 0);
        chk("postrst_rcN", rcN, 0);
        chk("postrst_vld", ovF, 0);
        issue(mov(5'd12), 32'd0, 32'd0);
        issue(mov(5'd1), 32'd0, 32'd0);
        idle(1);

        for (int i = 0; i < 20 && (qF.size() + qN.size()) != 0; i++)
            idle(1);
        chk("sb_drain", qF.size() + qN.size(), 0);
        chk("final_rc", rcF, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
